// File: rtl/vid_pkg.sv
// Video timing constants shared by the generator and capture paths, plus capture FSM encoding.
// Pure declarations: no latency, no flow control.
package vid_pkg;

  localparam logic [9:0] MAX_H     = 10'd1014;
  localparam logic [8:0] MAX_V     = 9'd261;
  localparam logic [9:0] HS_WID    = 10'd75;
  localparam logic [9:0] VS_WID    = 10'd942;
  localparam logic [8:0] VS_LIN    = 9'd248;
  localparam logic [8:0] BK_TOP    = 9'd16;
  localparam logic [8:0] BK_BOT    = 9'd240;
  localparam logic [9:0] ASTART    = 10'd185;
  // Generator holds a pixel for 3 clocks from ASTART; sample in the middle clock.
  localparam logic [9:0] PIX_START = ASTART + 10'd1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  function automatic logic [9:0] sat10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_sep.sv
// Synchronises luma/sync and classifies each sync-low pulse as H sync, V sync or glitch.
// Events are valid 2 clocks after the raw sync rising edge; no backpressure (free-running).
module sync_sep #(
  parameter logic [9:0] HS_MIN = 10'd40,
  parameter logic [9:0] HS_MAX = 10'd120,
  parameter logic [9:0] VS_MIN = 10'd800
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_luma,
  input  logic i_sync,
  output logic o_luma,
  output logic o_fall,
  output logic o_hs_ev,
  output logic o_vs_ev
);
  import vid_pkg::*;

  logic       r_sync_m, r_sync_s, r_sync_d;
  logic       r_luma_m, r_luma_s;
  logic [9:0] r_cnt;
  logic       w_fall, w_rise;

  assign w_fall = r_sync_d & ~r_sync_s;
  assign w_rise = ~r_sync_d & r_sync_s;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync_m <= 1'b0;
      r_sync_s <= 1'b0;
      r_sync_d <= 1'b0;
      r_luma_m <= 1'b0;
      r_luma_s <= 1'b0;
      r_cnt    <= 10'd0;
    end else begin
      r_sync_m <= i_sync;
      r_sync_s <= r_sync_m;
      r_sync_d <= r_sync_s;
      r_luma_m <= i_luma;
      r_luma_s <= r_luma_m;
      // The falling-edge clock is itself the first low clock of the pulse.
      if (w_fall)
        r_cnt <= 10'd1;
      else if (!r_sync_s)
        r_cnt <= sat10(r_cnt);
    end
  end

  assign o_luma  = r_luma_s;
  assign o_fall  = w_fall;
  assign o_hs_ev = w_rise && (r_cnt >= HS_MIN) && (r_cnt <= HS_MAX);
  assign o_vs_ev = w_rise && (r_cnt >= VS_MIN);

endmodule

// File: rtl/video_capture.sv
// Recovers line/frame timing from composite sync and writes 256x224 1-bit pixels as bytes to RAM.
// wr_en 1 clock after each 8th sample; no backpressure: the RAM port must accept every strobe.
module video_capture #(
  parameter logic [9:0] HS_MIN    = 10'd40,
  parameter logic [9:0] HS_MAX    = 10'd120,
  parameter logic [9:0] VS_MIN    = 10'd800,
  parameter logic [8:0] VS_LIN    = vid_pkg::VS_LIN,
  parameter logic [8:0] MAX_V     = vid_pkg::MAX_V,
  parameter logic [8:0] BK_TOP    = vid_pkg::BK_TOP,
  parameter logic [8:0] BK_BOT    = vid_pkg::BK_BOT,
  parameter logic [9:0] PIX_START = vid_pkg::PIX_START
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        luma,
  input  logic        sync,
  output logic        wr_en,
  output logic [12:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        locked,
  output logic        frame_done
);
  import vid_pkg::*;

  localparam logic [12:0] LAST_ADDR = {8'(BK_BOT - BK_TOP - 9'd1), 5'h1F};

  state_t      r_state, w_state_nxt;
  logic        w_luma, w_fall, w_hs_ev, w_vs_ev, w_ev, w_lost;
  logic        w_cap, w_pix_on, w_samp;
  logic [7:0]  w_row;
  logic [9:0]  r_tpos, r_hpos;
  logic [8:0]  r_vline, r_pix;
  logic [1:0]  r_ph;
  logic [6:0]  r_shift;
  logic        r_wrapped, r_miss;
  logic        r_wr_en, r_frame_done;
  logic [12:0] r_wr_addr;
  logic [7:0]  r_wr_data;

  sync_sep #(
    .HS_MIN(HS_MIN),
    .HS_MAX(HS_MAX),
    .VS_MIN(VS_MIN)
  ) u_sync_sep (
    .i_clk  (clk),
    .i_rst_n(reset_n),
    .i_luma (luma),
    .i_sync (sync),
    .o_luma (w_luma),
    .o_fall (w_fall),
    .o_hs_ev(w_hs_ev),
    .o_vs_ev(w_vs_ev)
  );

  assign w_ev     = w_hs_ev | w_vs_ev;
  assign w_lost   = w_hs_ev & r_miss;
  assign w_row    = 8'(r_vline - BK_TOP);
  assign w_cap    = (r_state == ACTIVE) && (r_vline >= BK_TOP) && (r_vline < BK_BOT);
  assign w_pix_on = (r_hpos >= PIX_START) && (r_hpos != 10'h3FF) && !r_pix[8];
  assign w_samp   = w_cap && w_pix_on && (r_ph == 2'd0);

  // r_tpos times every falling edge; r_hpos adopts it only once the pulse proves to be a real sync,
  // so a mid-line glitch leaves pixel timing untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tpos    <= 10'd0;
      r_hpos    <= 10'd0;
      r_vline   <= 9'd0;
      r_wrapped <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_tpos <= w_fall ? 10'd1 : sat10(r_tpos);
      r_hpos <= w_ev ? sat10(r_tpos) : sat10(r_hpos);
      if (w_vs_ev) begin
        r_vline   <= VS_LIN;
        r_wrapped <= 1'b0;
        r_miss    <= 1'b0;
      end else if (w_hs_ev) begin
        if (r_vline == MAX_V) begin
          r_vline   <= 9'd0;
          r_wrapped <= 1'b1;
          r_miss    <= r_wrapped;
        end else begin
          r_vline <= r_vline + 9'd1;
          r_miss  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix        <= 9'd0;
      r_ph         <= 2'd0;
      r_shift      <= 7'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 13'd0;
      r_wr_data    <= 8'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_frame_done <= r_wr_en && (r_wr_addr == LAST_ADDR);
      if (w_ev) begin
        r_pix <= 9'd0;
        r_ph  <= 2'd0;
      end else if (w_pix_on) begin
        r_ph <= (r_ph == 2'd2) ? 2'd0 : r_ph + 2'd1;
        if (r_ph == 2'd0)
          r_pix <= r_pix + 9'd1;
      end
      if (w_samp) begin
        r_shift <= {r_shift[5:0], w_luma};
        if (&r_pix[2:0]) begin
          r_wr_en   <= 1'b1;
          r_wr_data <= {r_shift, w_luma};
          r_wr_addr <= {w_row, r_pix[7:3]};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= HUNT;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    locked      = (r_state != HUNT);
    unique case (r_state)
      HUNT:   if (w_vs_ev) w_state_nxt = BLANK;
      BLANK: begin
        if (w_lost)
          w_state_nxt = HUNT;
        else if (w_hs_ev && (r_vline == BK_TOP - 9'd1) && enable)
          w_state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (w_lost)
          w_state_nxt = HUNT;
        else if (w_vs_ev || (w_hs_ev && (r_vline == BK_BOT - 9'd1)))
          w_state_nxt = BLANK;
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: table of captured-line patterns plus sequences for
// frame end, enable drop, lost vsync, relock and asynchronous reset.
module tb_video_capture;
  import vid_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        luma = 1'b0;
  logic        sync = 1'b1;
  logic        wr_en, locked, frame_done;
  logic [12:0] wr_addr;
  logic [7:0]  wr_data;

  video_capture dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .luma      (luma),
    .sync      (sync),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .locked    (locked),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam int P_WHITE = 0;
  localparam int P_BLACK = 1;
  localparam int P_ALT   = 2;
  localparam int P_RAMP  = 3;

  typedef struct {
    int         pat;
    int         glitch;
    logic [7:0] fill;
    int         nwr;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          fd_cnt = 0;
  int          wbase = 0;
  logic [20:0] wq[$];

  always @(negedge clk) begin
    if (wr_en) wq.push_back({wr_addr, wr_data});
    if (frame_done) fd_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL timeout: bench exceeded its time budget");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic pix_val(input int pat, input logic [7:0] row, input int k);
    logic [7:0] b;
    case (pat)
      P_WHITE: return 1'b1;
      P_BLACK: return 1'b0;
      P_ALT:   return (k % 2 == 0);
      default: begin
        b = {row[2:0], 5'(k / 8)};
        return b[7 - (k % 8)];
      end
    endcase
  endfunction

  // Cycle n of a line; n=0 is the sync falling edge. Pixel k occupies cycles 185+3k..187+3k.
  task automatic drive_step(input int n, input int low_w, input int pat, input logic [7:0] row,
                            input int glitch);
    @(posedge clk);
    #1;
    sync = ((n < low_w) || (glitch != 0 && n >= 500 && n < 530)) ? 1'b0 : 1'b1;
    luma = (n >= 185 && n < 185 + 768) ? pix_val(pat, row, (n - 185) / 3) : 1'b0;
  endtask

  task automatic drive_line(input int low_w, input int len, input int pat, input logic [7:0] row,
                            input int glitch);
    for (int n = 0; n < len; n++) drive_step(n, low_w, pat, row, glitch);
  endtask

  task automatic hs_line();
    drive_line(50, 60, P_BLACK, 8'd0, 0);
  endtask

  task automatic vs_line();
    drive_line(900, 920, P_BLACK, 8'd0, 0);
  endtask

  task automatic check_writes(input string nm, input logic [7:0] row, input int pat,
                              input logic [7:0] fill, input int nexp);
    int got;
    got = wq.size() - wbase;
    chk($sformatf("%s_count", nm), 32'(got), 32'(nexp));
    if (got == nexp) begin
      for (int j = 0; j < nexp; j++) begin
        logic [20:0] w;
        logic [7:0]  ed;
        w  = wq[wbase + j];
        ed = (pat == P_RAMP) ? {row[2:0], 5'(j)} : fill;
        chk($sformatf("%s_addr%0d", nm, j), 32'(w[20:8]), 32'({row, 5'(j)}));
        chk($sformatf("%s_data%0d", nm, j), 32'(w[7:0]), 32'(ed));
      end
    end
    wbase = wq.size();
  endtask

  vec_t tv[4];
  int   fd_base;
  int   n_lost;
  int   seen;

  initial begin
    tv[0] = '{pat: P_WHITE, glitch: 0, fill: 8'hFF, nwr: 32};
    tv[1] = '{pat: P_BLACK, glitch: 0, fill: 8'h00, nwr: 32};
    tv[2] = '{pat: P_ALT,   glitch: 0, fill: 8'hAA, nwr: 32};
    tv[3] = '{pat: P_RAMP,  glitch: 1, fill: 8'h00, nwr: 32};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(HUNT));
    reset_n = 1'b1;
    repeat (5) @(posedge clk);

    repeat (3) hs_line();
    chk("hunt_on_hs", 32'(locked), 32'd0);
    vs_line();
    chk("lock_on_vs", 32'(locked), 32'd1);
    chk("vline_vs", 32'(dut.r_vline), 32'd248);

    enable = 1'b1;
    repeat (29) hs_line();
    chk("vline_pre_active", 32'(dut.r_vline), 32'd15);
    wbase = wq.size();

    for (int i = 0; i < 4; i++) begin
      drive_line(50, 1000, tv[i].pat, 8'(i), tv[i].glitch);
      check_writes($sformatf("line%0d", 16 + i), 8'(i), tv[i].pat, tv[i].fill, tv[i].nwr);
    end
    chk("vline_after_glitch", 32'(dut.r_vline), 32'd19);

    for (int v = 20; v <= 238; v++) begin
      hs_line();
      if (v == 100) enable = 1'b0;
    end
    check_writes("short_lines", 8'd0, P_WHITE, 8'h00, 0);
    fd_base = fd_cnt;
    drive_line(50, 1000, P_WHITE, 8'd223, 0);
    check_writes("line239", 8'd223, P_WHITE, 8'hFF, 32);
    chk("frame_done_once", 32'(fd_cnt - fd_base), 32'd1);
    hs_line();
    chk("blank_after_frame", 32'(dut.r_state), 32'(BLANK));

    repeat (7) hs_line();
    vs_line();
    repeat (29) hs_line();
    drive_line(50, 1000, P_WHITE, 8'd0, 0);
    check_writes("disabled_frame", 8'd0, P_WHITE, 8'hFF, 0);
    chk("no_frame_done_disabled", 32'(fd_cnt - fd_base), 32'd1);

    n_lost = -1;
    for (int i = 1; i <= 300; i++) begin
      hs_line();
      if (!locked) begin
        n_lost = i;
        break;
      end
    end
    chk("lines_until_unlock", 32'(n_lost), 32'd247);
    chk("state_after_unlock", 32'(dut.r_state), 32'(HUNT));

    vs_line();
    chk("relock", 32'(locked), 32'd1);
    enable = 1'b1;
    repeat (29) hs_line();
    wbase = wq.size();
    drive_line(50, 1000, P_ALT, 8'd0, 0);
    check_writes("resume_line16", 8'd0, P_ALT, 8'hAA, 32);

    seen = 0;
    for (int n = 0; n < 1000; n++) begin
      drive_step(n, 50, P_RAMP, 8'd1, 0);
      if (wr_en) begin
        seen = 1;
        reset_n = 1'b0;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_state", 32'(dut.r_state), 32'(HUNT));
        chk("arst_wr_addr", 32'(wr_addr), 32'd0);
        break;
      end
    end
    chk("arst_wr_en_seen", 32'(seen), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/video_capture.md
Name: video_capture

Overview:
- Receiver for the 1-bit composite luma/sync pair that the video block drives.
- Separates H and V sync by pulse width and recovers line and frame timing.
- Samples 256 pixels per active line at clk/3, packs them MSB-first into bytes, and writes a 32-byte × 224-line bitmap through a RAM write port.
- Used for loopback self-test and capture of the video output.

Parameters:
- HS_MIN, 40: minimum sync-low width in clocks accepted as an H sync.
- HS_MAX, 120: maximum sync-low width accepted as an H sync.
- VS_MIN, 800: minimum sync-low width accepted as a V sync.
- VS_LIN, 248: line number assigned to the line carrying the V sync.
- MAX_V, 261: last line number; lines wrap 261 → 0.
- BK_TOP, 16: first active line.
- BK_BOT, 240: first line after the active area.
- PIX_START, 186: clocks from the sync falling edge to the sample point of pixel 0 (the centre of a 3-clock pixel).

Ports:
- clk  in  1  16MHz system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  capture request; level-sensitive.
- luma  in  1  video luminance input.
- sync  in  1  composite sync input, active low.
- wr_en  out  1  one-clock write strobe.
- wr_addr  out  13  write address {row[7:0], byte[4:0]}.
- wr_data  out  8  packed pixels, leftmost pixel in bit 7.
- locked  out  1  frame timing recovered.
- frame_done  out  1  one-clock pulse after the last byte of a captured frame.

Behaviour:
- Reset:
  - Asynchronous, active-low: all state clears immediately.
  - Outputs after reset: wr_en=0, wr_addr=0, wr_data=0, locked=0, frame_done=0. FSM enters HUNT.
- Input synchronisation:
  - luma and sync each pass through a 2-flop synchroniser.
  - Both paths have equal delay, so PIX_START is measured at the synchronised edge.
- Sync separator:
  - A 10-bit low-width counter clears on the synchronised sync falling edge and increments while sync=0, saturating at 1023.
  - The width is classified on the rising edge:
    - HS_MIN..HS_MAX produces an hs_ev pulse.
    - Width ≥ VS_MIN produces a vs_ev pulse.
    - Any other width is ignored as a glitch and produces no event.
- Line start:
  - Every sync falling edge clears a 10-bit hpos counter (saturates at 1023) and is tentatively a line start.
  - A line is counted only once its pulse classifies as hs_ev or vs_ev.
  - The line counter, vline (9-bit), advances on each classified event.
  - vs_ev loads vline=VS_LIN.
  - An hs_ev arriving while vline==MAX_V wraps vline to 0; otherwise hs_ev increments vline.
- FSM states:
  - HUNT: locked=0; waits for vs_ev → BLANK.
  - BLANK: locked=1; when a line with vline==BK_TOP starts and enable=1 → ACTIVE. If enable=0, stays in BLANK and keeps tracking.
  - ACTIVE: samples lines BK_TOP..BK_BOT-1. On the hs_ev that makes vline==BK_BOT → BLANK, with frame_done pulsed one clock after the final byte write.
  - From any locked state, if vline reaches MAX_V and hs_ev arrives twice more without vs_ev (line count overruns by 2) → HUNT, locked=0.
  - A vs_ev arriving while in ACTIVE → BLANK; the partial frame is abandoned and frame_done is not pulsed.
- Pixel sampling (ACTIVE, current line within BK_TOP..BK_BOT-1):
  - Pixel k (k=0..255) is sampled when hpos == PIX_START + 3k.
  - Samples shift into an 8-bit register MSB-first.
  - After every 8th sample, the next clock drives wr_en=1 with:
    - wr_data = the assembled byte;
    - wr_addr = {vline-BK_TOP truncated to 8 bits, k[7:3]}.
  - Writes per line: exactly 32; no write when hpos saturates.
  - A missing H sync (hpos ≥ 1023) produces no further samples on that line.
- enable:
  - Deassertion during ACTIVE takes effect only at frame end; the current frame completes.
  - Assertion during BLANK past line BK_TOP waits for the next frame.
- Latency: wr_en occurs 1 clock after the 8th sample of each byte.

Decomposition:
- vid_pkg holds the timing constants shared with the generator: MAX_H=1014, MAX_V, HS_WID=75, VS_WID=942, VS_LIN, BK_TOP, BK_BOT, ASTART=185, and a derived PIX_START. It also holds the FSM state encoding HUNT/BLANK/ACTIVE.
- sync_sep is a sub-module containing the synchroniser, low-width counter, classifier and hs_ev/vs_ev outputs.

Test Plan:
- Loopback the video generator in graphics mode with a RAM pattern of byte = addr[7:0] → after the second vsync, 7168 writes with wr_data matching the source at every wr_addr; frame_done pulses once per frame.
- 30-clock sync glitch mid-line → no event, vline unchanged, writes unaffected.
- Remove vsync for 3 frames → locked falls once vline overruns MAX_V by 2 lines. Restore vsync → locked=1 after the next vs_ev; capture resumes at line 16.
- Deassert enable at line 100 → writes continue through line 239 and frame_done pulses; no writes in the following frame.
- Assert reset_n=0 mid-line while wr_en is high → wr_en=0 immediately (asynchronous), FSM=HUNT, locked=0.
- All-white line (luma=1 throughout active area) → 32 writes of 8'hFF; all-black line → 8'h00; alternating 3-clock pixels → 8'hAA.
